// File: rtl/wide_add_seq_pkg.sv
// Shared constants for the sequential multi-word adder: the slice width and the FSM state encodings.
package wide_add_seq_pkg;

    localparam int SLICE_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/wide_add_seq_add16.sv
// 16-bit combinational carry-lookahead slice adder that uses four 4-bit lookahead groups.
// It also exports the carry into bit 15, which the parent uses to compute signed overflow.
module add16_slice
    import wide_add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               c15
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;

    assign w_g = x & y;
    assign w_p = x | y;

    // Each group forms its internal carries and its group carry directly from the group carry-in.
    always_comb begin
        logic v_gacc;
        logic v_pacc;
        w_c    = '0;
        w_c[0] = ci;
        for (int j = 0; j < SLICE_W / 4; j++) begin
            v_gacc = 1'b0;
            v_pacc = 1'b1;
            for (int i = 0; i < 4; i++) begin
                v_gacc = w_g[4*j+i] | (w_p[4*j+i] & v_gacc);
                v_pacc = v_pacc & w_p[4*j+i];
                w_c[4*j+i+1] = v_gacc | (v_pacc & w_c[4*j]);
            end
        end
    end

    assign s   = x ^ y ^ w_c[SLICE_W-1:0];
    assign co  = w_c[SLICE_W];
    assign c15 = w_c[SLICE_W-1];

endmodule

// File: rtl/wide_add_seq.sv
// Sequential WORDS*16-bit adder that processes one 16-bit slice per cycle, least significant slice first.
// The result is registered and is held in DONE until the consumer takes it.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int SLICE = SLICE_W
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SLICE*WORDS-1:0] a,
    input  logic [SLICE*WORDS-1:0] b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLICE*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);

    localparam int W     = SLICE * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [1:0]         r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_idx;

    logic [SLICE_W-1:0] w_x;
    logic [SLICE_W-1:0] w_y;
    logic [SLICE_W-1:0] w_s;
    logic               w_co;
    logic               w_c15;
    logic               w_last;

    assign w_x    = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_y    = r_b[r_idx*SLICE_W +: SLICE_W];
    assign w_last = (r_idx == IDX_W'(WORDS - 1));

    add16_slice u_slice (
        .x   (w_x),
        .y   (w_y),
        .ci  (r_carry),
        .s   (w_s),
        .co  (w_co),
        .c15 (w_c15)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[r_idx*SLICE_W +: SLICE_W] <= w_s;
                    r_carry                         <= w_co;
                    if (w_last) begin
                        r_cout  <= w_co;
                        r_ovf   <= w_c15 ^ w_co;
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq: directed corner cases followed by random operands with output stalls.
module tb_wide_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic         cout;
        logic         ovf;
        logic [W-1:0] sum;
    } res_t;

    res_t exp_q[$];
    int   n_sent = 0;
    int   n_recv = 0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        res_t       r;
        logic [W:0] full;
        full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair, waits for acceptance and then for out_valid. Leaves the DUT in DONE.
    task automatic send_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                           input string tag);
        int n;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
        exp_q.push_back(model(ta, tb, tc));
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, WORDS);
    endtask

    // Consumes the held result and compares it against the scoreboard head.
    task automatic take_result(input string tag);
        res_t e;
        chk({tag, "_out_valid"}, out_valid, 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_result"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, sum, e.sum);
            chk({tag, "_cout"}, cout, e.cout);
            chk({tag, "_ovf"}, ovf, e.ovf);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle_after"}, in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] held;
        res_t         er;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout_ovf", {cout, ovf}, 0);

        // A reset during RUN abandons the partial result.
        in_valid = 1'b1;
        a = 64'h0000_0000_0000_FFFF;
        b = 64'h1;
        cin = 1'b0;
        step();
        in_valid = 1'b0;
        chk("midrun_busy", busy, 1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_in_ready", in_ready, 1);
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_sum", sum, 0);

        send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, "ripple");
        chk("ripple_const", {cout, ovf, sum}, {2'b10, 64'h0});
        take_result("ripple");

        send_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "ovf");
        chk("ovf_const", {cout, ovf, sum}, {2'b01, 64'h8000_0000_0000_0000});
        take_result("ovf");

        send_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, "mixed");
        chk("mixed_const", {cout, ovf, sum}, {2'b00, 64'h2222_2222_2222_2211});

        // Backpressure: while in DONE, new operands must be ignored and the result must stay stable.
        held = sum;
        in_valid = 1'b1;
        a = 64'hDEAD_BEEF_0000_0001;
        b = 64'h0123_4567_89AB_CDEF;
        cin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0 || i == 9) begin
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_sum_held", sum, held);
            end
        end
        er = exp_q.pop_front();
        chk("bp_mixed_sum", sum, er.sum);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_idle", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        exp_q.push_back(model(a, b, cin));
        step();
        in_valid = 1'b0;
        chk("bp_accept_busy", busy, 1);
        for (int i = 0; i < WORDS - 1; i++) step();
        step();
        take_result("bp_new");

        // Random traffic: the driver and monitor run concurrently while the consumer stalls at random.
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    int n;
                    repeat ($urandom_range(0, 2)) step();
                    in_valid = 1'b1;
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    cin = 1'($urandom_range(0, 1));
                    if (k % 97 == 0) b = ~a;
                    n = 0;
                    while (!in_ready && n < 200) begin
                        step();
                        n++;
                    end
                    if (!in_ready) begin
                        chk("rnd_accept_timeout", 0, 1);
                        break;
                    end
                    exp_q.push_back(model(a, b, cin));
                    n_sent++;
                    step();
                    in_valid = 1'b0;
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (n_recv < 1000 && cyc < 40000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("rnd_unexpected_result", 1, 0);
                        end else begin
                            er = exp_q.pop_front();
                            chk("rnd_result", {cout, ovf, sum}, {er.cout, er.ovf, er.sum});
                        end
                        n_recv++;
                    end
                    step();
                    cyc++;
                end
                out_ready = 1'b0;
                if (n_recv < 1000) chk("rnd_monitor_timeout", n_recv, 1000);
            end
        join
        chk("rnd_count", n_recv, n_sent);
        chk("rnd_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
